// File: rtl/tune_pkg.sv
// tune_pkg -- shared types and helpers for the tuning sequencer.
//
// Contents:
//   tune_state_t : sequencer state (IDLE, SETTLE, MEASURE)
//   tune_dir_t   : tuning direction (UP, DOWN)
//   k_step()     : one-channel move of the DDS constant with band wrap
//
// The DDS constant width is fixed at DDS_W; the top-level width_dds
// parameter must match it.
package tune_pkg;

  localparam int unsigned DDS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2
  } tune_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } tune_dir_t;

  // Move k one channel in direction dir, wrapping at the band edges.
  // The comparison is done one bit wider than k so neither k + k_inc nor
  // k_min + k_inc can overflow near the top of the number range.
  function automatic logic [DDS_W-1:0] k_step(
    input logic [DDS_W-1:0] k,
    input tune_dir_t        dir,
    input logic [DDS_W-1:0] k_min,
    input logic [DDS_W-1:0] k_max,
    input logic [DDS_W-1:0] k_inc
  );
    logic [DDS_W:0] wide;
    if (dir == DIR_UP) begin
      wide = {1'b0, k} + {1'b0, k_inc};
      if (wide > {1'b0, k_max}) begin
        return k_min;
      end
      return wide[DDS_W-1:0];
    end
    wide = {1'b0, k_min} + {1'b0, k_inc};
    if ({1'b0, k} < wide) begin
      return k_max;
    end
    return k - k_inc;
  endfunction

endpackage

// File: rtl/tune_timer.sv
// tune_timer -- settle counter advanced by the time-base enable.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : time-base tick (one clk wide)
//   start        : clear the count (the sequencer is (re)entering SETTLE)
//   run          : sequencer is in SETTLE; ticks are counted only then
//   done         : combinational, high in the cycle whose tick completes
//                  SETTLE counted ticks
//
// An en arriving together with start is not counted: start wins.
module tune_timer #(
  parameter int unsigned SETTLE = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = run && en && !start && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && en) begin
      cnt_d = done ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tune_ctrl.sv
// tune_ctrl -- tuning sequencer for the FM receiver.
//
// Owns the DDS phase reload constant K, applies step / preset / seek
// requests, and mutes audio while the receiver settles after a retune.
//
// Optional feature macro: TUNE_CTRL_SEEK_EN
//   defined   : seek_up/seek_down, MEASURE state, seek_start and locked
//   undefined : seek and rssi inputs ignored, SETTLE always returns to IDLE,
//               locked tied to 0
//
// Ports:
//   clk, reset_n          : 240 MHz clock, asynchronous active-low reset
//   en                    : 32 kHz time-base tick (one clk wide)
//   step_up, step_down    : one-clk pulses, move one channel
//   seek_up, seek_down    : one-clk pulses, start a seek
//   preset_load, preset_k : load a (clamped) preset constant
//   rssi, rssi_valid      : signal level and its sample strobe
//   threshold             : seek stop level
//   K                     : DDS phase reload constant (registered)
//   mute                  : audio mute request
//   busy                  : sequencer not idle
//   locked                : last seek stopped on a station
module tune_ctrl
  import tune_pkg::*;
#(
  parameter int unsigned          width_dds  = 32,
  parameter int unsigned          width_rssi = 16,
  parameter logic [width_dds-1:0] K_MIN      = 32'h0CCC_CCCD,
  parameter logic [width_dds-1:0] K_MAX      = 32'h0E66_6666,
  parameter logic [width_dds-1:0] K_STEP     = 32'h0001_5D86,
  parameter logic [width_dds-1:0] K_RESET    = K_MIN,
  parameter int unsigned          SETTLE     = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  step_up,
  input  logic                  step_down,
  input  logic                  seek_up,
  input  logic                  seek_down,
  input  logic                  preset_load,
  input  logic [width_dds-1:0]  preset_k,
  input  logic [width_rssi-1:0] rssi,
  input  logic                  rssi_valid,
  input  logic [width_rssi-1:0] threshold,
  output logic [width_dds-1:0]  K,
  output logic                  mute,
  output logic                  busy,
  output logic                  locked
);

  tune_state_t          state_q, state_d;
  logic [width_dds-1:0] k_q, k_d;
  logic                 mute_q, busy_q;
  logic                 timer_start, timer_done;
  logic [width_dds-1:0] preset_clamped;
  logic                 step_req;
  tune_dir_t            step_dir;

  // Simultaneous up+down cancels out.
  assign step_req = step_up ^ step_down;
  assign step_dir = step_up ? DIR_UP : DIR_DOWN;

  always_comb begin
    preset_clamped = preset_k;
    if (preset_k < K_MIN) begin
      preset_clamped = K_MIN;
    end else if (preset_k > K_MAX) begin
      preset_clamped = K_MAX;
    end
  end

`ifdef TUNE_CTRL_SEEK_EN
  logic                 seek_act_q, seek_act_d;
  tune_dir_t            seek_dir_q, seek_dir_d;
  logic [width_dds-1:0] seek_start_q, seek_start_d;
  logic                 locked_q, locked_d;
  logic                 seek_req;
  tune_dir_t            seek_dir_req;
  logic [width_dds-1:0] seek_next;

  assign seek_req     = seek_up ^ seek_down;
  assign seek_dir_req = seek_up ? DIR_UP : DIR_DOWN;
  assign seek_next    = k_step(k_q, seek_dir_q, K_MIN, K_MAX, K_STEP);
  assign locked       = locked_q;
`else
  logic unused_seek;
  assign unused_seek = ^{seek_up, seek_down, rssi, rssi_valid, threshold};
  assign locked      = 1'b0;
`endif

  tune_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .start   (timer_start),
    .run     (state_q == ST_SETTLE),
    .done    (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    timer_start = 1'b0;
`ifdef TUNE_CTRL_SEEK_EN
    seek_act_d   = seek_act_q;
    seek_dir_d   = seek_dir_q;
    seek_start_d = seek_start_q;
    locked_d     = locked_q;
`endif

    if (preset_load) begin
      // Preset overrides everything, in every state, and restarts settling.
      k_d         = preset_clamped;
      state_d     = ST_SETTLE;
      timer_start = 1'b1;
`ifdef TUNE_CTRL_SEEK_EN
      seek_act_d = 1'b0;
      locked_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef TUNE_CTRL_SEEK_EN
          if (seek_req) begin
            seek_start_d = k_q;
            seek_dir_d   = seek_dir_req;
            seek_act_d   = 1'b1;
            locked_d     = 1'b0;
            k_d          = k_step(k_q, seek_dir_req, K_MIN, K_MAX, K_STEP);
            state_d      = ST_SETTLE;
            timer_start  = 1'b1;
          end else
`endif
          if (step_req) begin
            k_d         = k_step(k_q, step_dir, K_MIN, K_MAX, K_STEP);
            state_d     = ST_SETTLE;
            timer_start = 1'b1;
`ifdef TUNE_CTRL_SEEK_EN
            locked_d = 1'b0;
`endif
          end
        end

        ST_SETTLE: begin
          if (timer_done) begin
`ifdef TUNE_CTRL_SEEK_EN
            state_d = seek_act_q ? ST_MEASURE : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
          end
        end

`ifdef TUNE_CTRL_SEEK_EN
        ST_MEASURE: begin
          if (rssi_valid) begin
            if (rssi >= threshold) begin
              locked_d   = 1'b1;
              seek_act_d = 1'b0;
              state_d    = ST_IDLE;
            end else if (seek_next == seek_start_q) begin
              // Wrapped all the way round without a station: settle back
              // on the original channel with the seek finished.
              locked_d    = 1'b0;
              seek_act_d  = 1'b0;
              k_d         = seek_start_q;
              state_d     = ST_SETTLE;
              timer_start = 1'b1;
            end else begin
              k_d         = seek_next;
              state_d     = ST_SETTLE;
              timer_start = 1'b1;
            end
          end
        end
`endif

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SETTLE;
      k_q     <= K_RESET;
      mute_q  <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mute_q  <= (state_d != ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

`ifdef TUNE_CTRL_SEEK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seek_act_q   <= 1'b0;
      seek_dir_q   <= DIR_UP;
      seek_start_q <= K_RESET;
      locked_q     <= 1'b0;
    end else begin
      seek_act_q   <= seek_act_d;
      seek_dir_q   <= seek_dir_d;
      seek_start_q <= seek_start_d;
      locked_q     <= locked_d;
    end
  end
`endif

  assign K    = k_q;
  assign mute = mute_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_tune_ctrl.sv
// Testbench for tune_ctrl. Band 100..200 step 10, settle 4 en ticks,
// en every 8 clk. Seek scenarios run when TUNE_CTRL_SEEK_EN is defined,
// otherwise the seek inputs are checked to be ignored.
module tb_tune_ctrl;

  localparam int KMIN     = 100;
  localparam int KMAX     = 200;
  localparam int KSTEP    = 10;
  localparam int SETTLE_N = 4;

  logic        clk = 1'b0;
  logic        reset_n, en;
  logic        step_up, step_down, seek_up, seek_down, preset_load, rssi_valid;
  logic [31:0] preset_k;
  logic [15:0] rssi, threshold;
  logic [31:0] K;
  logic        mute, busy, locked;

  int errors = 0;
  int checks = 0;
  int model_k;
  int phase = 0;

  tune_ctrl #(
    .width_dds  (32),
    .width_rssi (16),
    .K_MIN      (32'd100),
    .K_MAX      (32'd200),
    .K_STEP     (32'd10),
    .K_RESET    (32'd100),
    .SETTLE     (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .step_up     (step_up),
    .step_down   (step_down),
    .seek_up     (seek_up),
    .seek_down   (seek_down),
    .preset_load (preset_load),
    .preset_k    (preset_k),
    .rssi        (rssi),
    .rssi_valid  (rssi_valid),
    .threshold   (threshold),
    .K           (K),
    .mute        (mute),
    .busy        (busy),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  // en: one clk wide every 8 clk, changing 2 time units after posedge.
  initial begin
    en = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      phase = (phase + 1) % 8;
      en = (phase == 0);
    end
  end

  // Reference rules for the band.
  function automatic int m_up(input int k);
    return (k + KSTEP > KMAX) ? KMIN : k + KSTEP;
  endfunction
  function automatic int m_dn(input int k);
    return (k < KMIN + KSTEP) ? KMAX : k - KSTEP;
  endfunction
  function automatic int m_clamp(input int k);
    if (k < KMIN) return KMIN;
    if (k > KMAX) return KMAX;
    return k;
  endfunction

  // Drive a one-cycle request; called and returns at a negedge.
  task automatic pulse_in(input logic ku, input logic kd, input logic su,
                          input logic sd, input logic pl, input int pk);
    step_up = ku; step_down = kd; seek_up = su; seek_down = sd;
    preset_load = pl; preset_k = 32'(pk);
    @(negedge clk);
    step_up = 0; step_down = 0; seek_up = 0; seek_down = 0; preset_load = 0;
  endtask

  task automatic rssi_pulse(input int r);
    rssi = 16'(r); rssi_valid = 1'b1;
    @(negedge clk);
    rssi_valid = 1'b0;
  endtask

  // Follow one settle period: busy/mute/K must hold steady until SETTLE_N
  // en ticks have been seen. Optionally throws in step/seek pulses at cycle
  // drop_at, which must be dropped. Returns at the negedge after the edge
  // that consumed the final tick.
  task automatic wait_settle(input string name, input int k_exp, input int drop_at);
    int n = 0;
    int cyc = 0;
    bit bad = 0;
    while (n < SETTLE_N && cyc < 200) begin
      if (busy !== 1'b1 || mute !== 1'b1 || K !== 32'(k_exp)) bad = 1;
      step_up   = (cyc == drop_at);
      seek_down = (cyc == drop_at);
      if (en) n++;
      @(negedge clk);
      cyc++;
    end
    step_up = 0; seek_down = 0;
    checks++;
    if (bad || n < SETTLE_N) begin
      errors++;
      $display("FAIL settle_%s: K=%0d busy=%b mute=%b en_seen=%0d, required K=%0d busy=mute=1 for %0d en",
               name, K, busy, mute, n, k_exp, SETTLE_N);
    end else begin
      $display("settle %s: K=%0d held for %0d en ticks", name, K, n);
    end
  endtask

  // kind: 0 step_up, 1 step_down, 2 preset, 3 both steps (ignored)
  task automatic step_op(input string name, input int kind, input int pk, input int drop_at);
    int exp;
    bit ignored = 0;
    case (kind)
      0: exp = m_up(model_k);
      1: exp = m_dn(model_k);
      2: exp = m_clamp(pk);
      default: begin exp = model_k; ignored = 1; end
    endcase
    pulse_in(kind == 0 || kind == 3, kind == 1 || kind == 3, 0, 0, kind == 2, pk);
    checks++;
    if (ignored) begin
      if (busy !== 1'b0 || K !== 32'(exp)) begin
        errors++;
        $display("FAIL ignored_%s: K=%0d busy=%b, required K=%0d busy=0", name, K, busy, exp);
      end else $display("op %s: both steps ignored, K=%0d", name, K);
    end else begin
      if (busy !== 1'b1 || mute !== 1'b1 || K !== 32'(exp)) begin
        errors++;
        $display("FAIL latency_%s: K=%0d busy=%b mute=%b, required K=%0d busy=1 mute=1",
                 name, K, busy, mute, exp);
      end else $display("op %s: kind=%0d K=%0d", name, kind, K);
      wait_settle(name, exp, drop_at);
      checks++;
      if ({busy, mute, locked} !== 3'b000 || K !== 32'(exp)) begin
        errors++;
        $display("FAIL idle_%s: K=%0d busy=%b mute=%b locked=%b, required K=%0d busy=mute=locked=0",
                 name, K, busy, mute, locked, exp);
      end
    end
    model_k = exp;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({K, mute, busy, locked} !== {32'd100, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: K=%0d mute=%b busy=%b locked=%b, required 100 1 1 0", K, mute, busy, locked);
    end else $display("reset: K=%0d mute=%b busy=%b", K, mute, busy);
    reset_n = 1'b1;
    wait_settle("reset", 100, -1);
    checks++;
    if ({busy, mute} !== 2'b00 || K !== 32'd100) begin
      errors++;
      $display("FAIL reset_unmute: K=%0d busy=%b mute=%b, required 100 0 0", K, busy, mute);
    end
    model_k = 100;
  endtask

  task automatic test_step_wrap();
    step_op("preset195", 2, 195, -1);
    step_op("wrap_up", 0, 0, -1);
    step_op("wrap_down", 1, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int kind = $urandom_range(0, 3);
      int pk   = $urandom_range(0, 300);
      int drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
      repeat ($urandom_range(0, 9)) @(negedge clk);
      step_op($sformatf("rnd%0d", i), kind, pk, drop);
    end
  endtask

  // A request (seek when available, else step) interrupted mid-settle by a
  // preset that arrives together with a step_up.
  task automatic test_preempt();
    step_op("pre_base", 2, 150, -1);
`ifdef TUNE_CTRL_SEEK_EN
    threshold = 16'd0;
    pulse_in(0, 0, 1, 0, 0, 0);
`else
    pulse_in(1, 0, 0, 0, 0, 0);
`endif
    checks++;
    if (K !== 32'd160 || busy !== 1'b1) begin
      errors++;
      $display("FAIL preempt_start: K=%0d busy=%b, required 160 1", K, busy);
    end
    repeat (3) @(negedge clk);
    pulse_in(1, 0, 0, 0, 1, 250);
    checks++;
    if (K !== 32'd200 || busy !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL preempt_load: K=%0d busy=%b locked=%b, required 200 1 0", K, busy, locked);
    end else $display("preempt: preset 250 -> K=%0d", K);
    wait_settle("preempt", 200, -1);
    checks++;
    if ({busy, mute, locked} !== 3'b000 || K !== 32'd200) begin
      errors++;
      $display("FAIL preempt_end: K=%0d busy=%b mute=%b locked=%b, required 200 0 0 0", K, busy, mute, locked);
    end
    model_k = 200;
  endtask

`ifdef TUNE_CTRL_SEEK_EN
  task automatic test_seek_hit();
    step_op("hit_base", 2, 120, -1);
    threshold = 16'd50;
    pulse_in(0, 0, 1, 0, 0, 0);
    checks++;
    if (K !== 32'd130 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hit_first: K=%0d busy=%b, required 130 1", K, busy);
    end
    wait_settle("hit130", 130, -1);
    rssi_pulse(10);
    checks++;
    if (K !== 32'd140 || busy !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL hit_next: K=%0d busy=%b locked=%b, required 140 1 0", K, busy, locked);
    end
    wait_settle("hit140", 140, -1);
    rssi_pulse(60);
    checks++;
    if (K !== 32'd140 || {busy, mute, locked} !== 3'b001) begin
      errors++;
      $display("FAIL hit_lock: K=%0d busy=%b mute=%b locked=%b, required 140 0 0 1", K, busy, mute, locked);
    end else $display("seek hit: K=%0d locked=%b", K, locked);
    model_k = 140;
    step_op("unlock_step", 0, 0, -1);
  endtask

  // Seek from start in direction dn; rssi either random or always 0.
  task automatic run_seek(input string name, input int start, input bit dn,
                          input int thr, input bit rnd);
    int k;
    int visited = 1;
    step_op({name, "_base"}, 2, start, -1);
    threshold = 16'(thr);
    pulse_in(0, 0, !dn, dn, 0, 0);
    k = dn ? m_dn(start) : m_up(start);
    for (int ch = 0; ch < 15; ch++) begin
      int r;
      int nk;
      visited++;
      checks++;
      if (K !== 32'(k) || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_chan: K=%0d busy=%b, required %0d 1", name, K, busy, k);
      end
      wait_settle(name, k, -1);
      r = rnd ? int'($urandom_range(0, 100)) : 0;
      rssi_pulse(r);
      if (r >= thr) begin
        checks++;
        if (K !== 32'(k) || {busy, locked} !== 2'b01) begin
          errors++;
          $display("FAIL %s_lock: K=%0d busy=%b locked=%b, required %0d 0 1", name, K, busy, locked, k);
        end else $display("seek %s: locked at K=%0d", name, K);
        model_k = k;
        break;
      end
      nk = dn ? m_dn(k) : m_up(k);
      if (nk == start) begin
        wait_settle({name, "_back"}, start, -1);
        checks++;
        if (K !== 32'(start) || {busy, mute, locked} !== 3'b000 || visited != 11) begin
          errors++;
          $display("FAIL %s_band: K=%0d busy=%b mute=%b locked=%b visited=%0d, required %0d 0 0 0 11",
                   name, K, busy, mute, locked, visited, start);
        end else $display("seek %s: full band, back at K=%0d", name, K);
        model_k = start;
        break;
      end
      k = nk;
    end
  endtask

  task automatic test_seek_band();
    run_seek("band", 150, 1'b1, 50, 1'b0);
  endtask

  task automatic test_seek_random();
    for (int i = 0; i < 3; i++) begin
      run_seek($sformatf("rseek%0d", i), KMIN + KSTEP * int'($urandom_range(0, 10)),
               1'($urandom_range(0, 1)), int'($urandom_range(60, 100)), 1'b1);
    end
  endtask
`else
  task automatic test_seek_off();
    bit bad = 0;
    threshold = 16'd0;
    pulse_in(0, 0, 1, 0, 0, 0);
    rssi_pulse(100);
    pulse_in(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || K !== 32'(model_k) || locked !== 1'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL seek_off: K=%0d busy=%b locked=%b, required K=%0d busy=0 locked=0", K, busy, locked, model_k);
    end else $display("seek off: seek pulses ignored, K=%0d", K);
  endtask
`endif

  task automatic test_reset_mid();
    pulse_in(1, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({K, mute, busy, locked} !== {32'd100, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: K=%0d mute=%b busy=%b locked=%b, required 100 1 1 0", K, mute, busy, locked);
    end else $display("reset mid-op: K=%0d", K);
    @(negedge clk);
    reset_n = 1'b1;
    wait_settle("reset_mid", 100, -1);
    checks++;
    if ({busy, mute} !== 2'b00 || K !== 32'd100) begin
      errors++;
      $display("FAIL reset_mid_unmute: K=%0d busy=%b mute=%b, required 100 0 0", K, busy, mute);
    end
    model_k = 100;
  endtask

  initial begin
    reset_n = 1'b0;
    step_up = 0; step_down = 0; seek_up = 0; seek_down = 0;
    preset_load = 0; preset_k = '0; rssi = '0; rssi_valid = 0; threshold = '0;
    test_reset();
    test_step_wrap();
    test_random();
    test_preempt();
`ifdef TUNE_CTRL_SEEK_EN
    test_seek_hit();
    test_seek_band();
    test_seek_random();
`else
    test_seek_off();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
